// File: rtl/hdmi_vpg_param.sv
// Parametrised video timing generator with RGB565 -> RGB888 formatter.
// Three-stage pipeline: counters/pix_req, pixel arrival, registered outputs.
module hdmi_vpg_param #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int HS_POL      = 0,
  parameter int VS_POL      = 0,
  parameter int START_LINES = 2,
  parameter int CNT_W       = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] pixel,
  input  logic [1:0]  mode,
  input  logic [4:0]  th_r,
  input  logic [5:0]  th_g,
  input  logic [4:0]  th_b,
  output logic        pclk,
  output logic        pix_req,
  output logic        frame_start,
  output logic        hs,
  output logic        vs,
  output logic        de,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int WAIT_CYC = (START_LINES * H_TOTAL > 0) ? START_LINES * H_TOTAL : 1;
  localparam int WAIT_W   = $clog2(WAIT_CYC + 1);

  localparam logic [CNT_W-1:0]  H_LAST  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0]  V_LAST  = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0]  H_ACT_C = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0]  V_ACT_C = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0]  HS_BEG  = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0]  HS_END  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0]  VS_BEG  = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0]  VS_END  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [WAIT_W-1:0] W_LAST  = WAIT_W'(WAIT_CYC - 1);
  localparam logic              HS_ON   = 1'(HS_POL);
  localparam logic              VS_ON   = 1'(VS_POL);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RUN} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   h_q, h_d, v_q, v_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;

  // Stage 0/1/2 pipeline registers
  logic        req_q, fs_q, hs0_q, vs0_q;
  logic        de1_q, hs1_q, vs1_q;
  logic        de2_q, hs2_q, vs2_q;
  logic [23:0] rgb_q;
  logic        req_d, fs_d, hs0_d, vs0_d;
  logic [23:0] rgb_d;

  logic [1:0] sh_mode_q;
  logic [4:0] sh_tr_q, sh_tb_q;
  logic [5:0] sh_tg_q;

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    wait_d  = wait_q;
    case (state_q)
      S_IDLE: begin
        h_d    = '0;
        v_d    = '0;
        wait_d = '0;
        if (en) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!en) begin
          state_d = S_IDLE;
          wait_d  = '0;
        end else if (wait_q == W_LAST) begin
          state_d = S_RUN;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_RUN: begin
        if (h_q == H_LAST) begin
          h_d = '0;
          if (v_q == V_LAST) begin
            v_d = '0;
            // A dropped enable only takes effect at the frame boundary.
            if (!en) state_d = S_IDLE;
          end else begin
            v_d = v_q + 1'b1;
          end
        end else begin
          h_d = h_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // pix_req is a fire-and-forget request: no backpressure, upstream must
  // present the pixel exactly one cycle after each pix_req.
  always_comb begin
    req_d = (state_d == S_RUN) && (h_d < H_ACT_C) && (v_d < V_ACT_C);
    fs_d  = (state_d == S_RUN) && (h_d == '0) && (v_d == '0);
    hs0_d = ((h_d >= HS_BEG) && (h_d < HS_END)) ? HS_ON : ~HS_ON;
    vs0_d = ((v_d >= VS_BEG) && (v_d < VS_END)) ? VS_ON : ~VS_ON;
  end

  logic [4:0] pr, pb, y;
  logic [5:0] pg;
  logic [6:0] sum;
  logic [23:0] rgb_plain;
  logic        th_dark;

  always_comb begin
    pr        = pixel[15:11];
    pg        = pixel[10:5];
    pb        = pixel[4:0];
    rgb_plain = {pr, pr[4:2], pg, pg[5:4], pb, pb[4:2]};
    sum       = {2'b00, pr} + {2'b00, pg[5:1]} + {2'b00, pb};
    y         = 5'(sum / 7'd3);
    th_dark   = (pr > sh_tr_q) || (pg > sh_tg_q) || (pb < sh_tb_q);
    rgb_d     = 24'h000000;
    if (de1_q) begin
      case (sh_mode_q)
        2'd0:    rgb_d = rgb_plain;
        2'd1:    rgb_d = {3{y, y[4:2]}};
        2'd2:    rgb_d = th_dark ? 24'h000000 : 24'hFFFFFF;
        default: rgb_d = ~rgb_plain;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      h_q       <= '0;
      v_q       <= '0;
      wait_q    <= '0;
      req_q     <= 1'b0;
      fs_q      <= 1'b0;
      hs0_q     <= ~HS_ON;
      vs0_q     <= ~VS_ON;
      de1_q     <= 1'b0;
      hs1_q     <= ~HS_ON;
      vs1_q     <= ~VS_ON;
      de2_q     <= 1'b0;
      hs2_q     <= ~HS_ON;
      vs2_q     <= ~VS_ON;
      rgb_q     <= '0;
      sh_mode_q <= 2'd0;
      sh_tr_q   <= '0;
      sh_tg_q   <= '0;
      sh_tb_q   <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
      wait_q  <= wait_d;
      req_q   <= req_d;
      fs_q    <= fs_d;
      hs0_q   <= hs0_d;
      vs0_q   <= vs0_d;
      de1_q   <= req_q;
      hs1_q   <= hs0_q;
      vs1_q   <= vs0_q;
      de2_q   <= de1_q;
      hs2_q   <= hs1_q;
      vs2_q   <= vs1_q;
      rgb_q   <= rgb_d;
      // Shadowed per frame so a frame never mixes two modes.
      if (fs_q) begin
        sh_mode_q <= mode;
        sh_tr_q   <= th_r;
        sh_tg_q   <= th_g;
        sh_tb_q   <= th_b;
      end
    end
  end

  assign pclk        = clk;
  assign pix_req     = req_q;
  assign frame_start = fs_q;
  assign de          = de2_q;
  assign hs          = hs2_q;
  assign vs          = vs2_q;
  assign vga_r       = rgb_q[23:16];
  assign vga_g       = rgb_q[15:8];
  assign vga_b       = rgb_q[7:0];

endmodule

// File: doc/hdmi_vpg_param.md
Name: hdmi_vpg_param

Overview:
Parametrised HDMI/VGA video pattern generator and pixel formatter, the successor to the fixed 640x480 generator. It generates programmable H/V timing with selectable sync polarity and a gated startup delay. It requests RGB565 pixels from the upstream frame buffer and emits 24-bit RGB in one of four display modes. Mode and thresholds are latched per frame, so frames never tear. It sits between the camera line buffer and the HDMI transmitter.

Parameters:
H_ACTIVE, 640, active pixels per line
H_FP, 16, horizontal front porch (cycles)
H_SYNC, 96, hsync width (cycles)
H_BP, 48, horizontal back porch (cycles)
V_ACTIVE, 480, active lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, hsync active level (0 = active-low)
VS_POL, 0, vsync active level
START_LINES, 2, line periods to wait after enable before the first frame
CNT_W, 12, width of the h/v counters; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
clk  in  1  pixel clock
rst  in  1  synchronous active-high reset
en  in  1  start/continue video output
pixel  in  16  RGB565 pixel {R[15:11],G[10:5],B[4:0]}, valid one cycle after pix_req
mode  in  2  0=RGB, 1=GREY, 2=THRESHOLD, 3=INVERT
th_r  in  5  red threshold
th_g  in  6  green threshold
th_b  in  5  blue threshold
pclk  out  1  equals clk
pix_req  out  1  pixel request to upstream, one per active pixel
frame_start  out  1  one-cycle pulse, coincident with the first pix_req of each frame
hs  out  1  horizontal sync
vs  out  1  vertical sync
de  out  1  data enable
vga_r  out  8  red
vga_g  out  8  green
vga_b  out  8  blue

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL likewise (default 525).
- Line layout: h 0..H_ACTIVE-1 is active, then FP, sync, BP. The frame layout is the same order in v.
- Counter h wraps at H_TOTAL-1. v increments only on the h wrap and wraps at V_TOTAL-1.
- hs is active while H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC. vs is active while V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC.
- FSM states:
  - IDLE: counters held at 0. Leaves to WAIT when en=1.
  - WAIT: counts exactly START_LINES*H_TOTAL cycles, then goes to RUN with h=v=0.
  - RUN: free-running timing.
- en=0 in RUN: the current frame completes. At the v/h wrap the FSM returns to IDLE instead of starting a new frame. Reasserting en repeats WAIT.
- en=0 in WAIT: return to IDLE next cycle and clear the wait counter.
- Pipeline stages:
  - Stage 0 (counters): pix_req registered = (h<H_ACTIVE && v<V_ACTIVE && RUN).
  - Stage 1: pixel sampled (upstream presents it the cycle after pix_req).
  - Stage 2: registered outputs.
  - de, hs, vs and RGB are all delayed to stage 2, so de follows pix_req by exactly 2 cycles and hs/vs stay aligned with de.
- mode, th_r, th_g, th_b are latched into shadow registers on the cycle frame_start=1. Changes mid-frame take effect at the next frame.
- RGB mode: bit-replicate MSBs: r={R,R[4:2]}, g={G,G[5:4]}, b={B,B[4:2]}.
- GREY mode:
  - sum = R + G[5:1] + B, 7 bits, max 93.
  - y = sum/3, exact integer division, 5 bits.
  - r=g=b={y,y[4:2]}.
- THRESHOLD mode: output 24'h000000 if (R>th_r) or (G>th_g) or (B<th_b), else 24'hFFFFFF.
- INVERT mode: bitwise NOT of the RGB-mode result.
- When de=0, vga_r/g/b = 0.
- Reset (any time, including mid-frame):
  - Next cycle: state IDLE, counters 0, pipeline cleared.
  - Outputs: pix_req=0, frame_start=0, de=0, rgb=0, hs=~HS_POL, vs=~VS_POL.
  - Shadow mode=0 (RGB) and shadow thresholds=0.
- rst has priority over en.

Test Plan:
- Reset with defaults, rst held 5 cycles -> hs=1, vs=1, de=0, pix_req=0, rgb=0 in every cycle; stays so with en=0.
- en=1 sampled at edge 10 -> WAIT entered at 11; first pix_req and frame_start at cycle 1611; first de at 1613.
- Timing check, RUN for 2 frames -> per line 640 de cycles and hs low for 96 cycles starting 656 cycles after de rises; line period 800; vs low for 2 lines; frame period 420000 cycles.
- Mode values:
  - GREY, pixel 16'hFFFF -> rgb FFFFFF; pixel 16'h8410 -> 848484.
  - RGB, 16'hF800 -> FF0000.
  - INVERT, 16'hF800 -> 00FFFF.
  - THRESHOLD with th_r=11, th_g=25, th_b=8: R=5,G=10,B=20 -> FFFFFF; R=12 -> 000000.
- mode changed RGB->GREY during line 100 -> output stays RGB for the rest of that frame; GREY from the next frame_start.
- en dropped at line 200 -> frame finishes to line 524, then de/pix_req stay 0 and hs/vs inactive. rst asserted mid-line -> reset values on the next cycle; re-enable shows the full 1600-cycle WAIT again.
